// File: rtl/reg_dump_sequencer_pkg.sv
// Shared definitions for the register-file debug dump path.
// Contents:
//   REG_ADDR_W, REG_DATA_W : register file geometry
//   DUMP_HEADER            : first byte of every dump frame
//   S_IDLE..S_FIN          : 3-bit state encodings, wrapped by dump_state_t
//   csum_update            : running XOR checksum step
package reg_dump_sequencer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_LOAD = 3'd4;
    localparam logic [2:0] S_SEND = 3'd5;
    localparam logic [2:0] S_CSUM = 3'd6;
    localparam logic [2:0] S_FIN  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_HDR  = S_HDR,
        ST_ADDR = S_ADDR,
        ST_WAIT = S_WAIT,
        ST_LOAD = S_LOAD,
        ST_SEND = S_SEND,
        ST_CSUM = S_CSUM,
        ST_FIN  = S_FIN
    } dump_state_t;

    // Checksum covers data bytes only; the caller never feeds it the header.
    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/reg_dump_sequencer_word_serializer.sv
// Word-to-byte serializer for the register dump stream.
// Loads a DATA_W word and presents it MSB byte first; each 'advance'
// shifts the next byte up. The owner supplies valid and decides acceptance.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load, word_in  : capture a new word (byte count := DATA_W/8)
//   advance        : current byte was accepted, move to the next one
//   byte_out       : byte currently presented
//   next_byte      : byte that will be presented after one advance
//   last           : byte_out is the final byte of the word
module word_serializer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              advance,
    output logic [7:0]        byte_out,
    output logic [7:0]        next_byte,
    output logic              last
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic [DATA_W-1:0] shift_r;
    logic [CNT_W-1:0]  count_r;

    // Shift register and remaining-byte counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_r <= '0;
            count_r <= '0;
        end else if (load) begin
            shift_r <= word_in;
            count_r <= CNT_W'(NBYTES);
        end else if (advance && (count_r != '0)) begin
            shift_r <= shift_r << 4'd8;
            count_r <= count_r - CNT_W'(1);
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

    assign byte_out = shift_r[DATA_W-1 -: 8];
    assign last     = (count_r == CNT_W'(1));

    // A single-byte word has no successor byte.
    generate
        if (DATA_W > 8) begin : g_next
            assign next_byte = shift_r[DATA_W-9 -: 8];
        end else begin : g_no_next
            assign next_byte = 8'h00;
        end
    endgenerate

endmodule

// File: rtl/reg_dump_sequencer.sv
// Debug controller that snapshots the register file and streams it out a
// byte-wide UART TX port as: HEADER, each register MSB byte first, XOR checksum.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   start          : one-cycle request, only honoured in IDLE
//   dump_active    : high while a frame is in progress (read-port mux select)
//   rd_addr        : register address to the register file
//   rd_data        : register data, valid one clock after rd_addr is sampled
//   tx_data, tx_valid, tx_ready : byte stream to the UART (valid/ready)
//   done           : one-cycle pulse after the checksum byte is accepted
module reg_dump_sequencer
    import reg_dump_sequencer_pkg::*;
#(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = REG_ADDR_W,
    parameter int         DATA_W   = REG_DATA_W,
    parameter logic [7:0] HEADER   = DUMP_HEADER
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              dump_active,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_r, state_s;
    logic [ADDR_W-1:0] index_r, index_s;
    logic [7:0]        csum_r, csum_s;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              tx_valid_r;
    logic              dump_active_r;
    logic              done_r;

    logic              accept_s;
    logic              ser_load_s;
    logic              ser_adv_s;
    logic [7:0]        ser_byte_s;
    logic [7:0]        ser_next_s;
    logic              ser_last_s;

    word_serializer #(
        .DATA_W (DATA_W)
    ) u_word_serializer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ser_load_s),
        .word_in   (rd_data),
        .advance   (ser_adv_s),
        .byte_out  (ser_byte_s),
        .next_byte (ser_next_s),
        .last      (ser_last_s)
    );

    assign accept_s = tx_valid_r & tx_ready;

    // Next-state, index/checksum update and the next value of tx_data.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        csum_s     = csum_r;
        ser_load_s = 1'b0;
        ser_adv_s  = 1'b0;
        tx_data_s  = 8'h00;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_HDR;
                    index_s = '0;
                    csum_s  = 8'h00;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_HDR;
                end
            end
            ST_ADDR: state_s = ST_WAIT;
            ST_WAIT: state_s = ST_LOAD;
            ST_LOAD: begin
                ser_load_s = 1'b1;
                state_s    = ST_SEND;
            end
            ST_SEND: begin
                if (accept_s) begin
                    ser_adv_s = 1'b1;
                    csum_s    = csum_update(csum_r, ser_byte_s);
                    if (!ser_last_s) begin
                        state_s = ST_SEND;
                    end else if (index_r == LAST_IDX) begin
                        state_s = ST_CSUM;
                    end else begin
                        index_s = index_r + ADDR_W'(1);
                        state_s = ST_ADDR;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase

        // tx_data is registered, so pick the byte the next state presents:
        // the fresh word's MSB byte on entry to SEND, the successor byte
        // after an accept, otherwise the byte already on the wire.
        case (state_s)
            ST_HDR:  tx_data_s = HEADER;
            ST_SEND: begin
                if (state_r == ST_LOAD) begin
                    tx_data_s = rd_data[DATA_W-1 -: 8];
                end else if (accept_s) begin
                    tx_data_s = ser_next_s;
                end else begin
                    tx_data_s = ser_byte_s;
                end
            end
            ST_CSUM: tx_data_s = csum_s;
            default: tx_data_s = 8'h00;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            index_r       <= '0;
            csum_r        <= 8'h00;
            rd_addr_r     <= '0;
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            dump_active_r <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            index_r       <= index_s;
            csum_r        <= csum_s;
            tx_data_r     <= tx_data_s;
            tx_valid_r    <= (state_s == ST_HDR) || (state_s == ST_SEND) || (state_s == ST_CSUM);
            dump_active_r <= (state_s != ST_IDLE) && (state_s != ST_FIN);
            done_r        <= (state_s == ST_FIN);
            // Address is latched on entry to ADDR and held through WAIT/LOAD/SEND.
            if (state_s == ST_ADDR) begin
                rd_addr_r <= index_s;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
        end
    end

    assign rd_addr     = rd_addr_r;
    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign dump_active = dump_active_r;
    assign done        = done_r;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: register-file model, byte-stream
// reference built from the register contents, a per-cycle stream monitor and
// a directed/randomised sequence of dumps.
module tb_reg_dump_sequencer;

    localparam int FRAME = 130;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic        dump_active;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        done;

    logic [31:0] mem [32];
    logic [7:0]  expb [FRAME];
    logic [7:0]  cap [FRAME];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pos = 0;
    int dones = 0;
    int hdr_cyc = 0;
    int done_cyc = 0;
    int lat = 0;
    int gap = 0;
    bit in_frame = 1'b0;
    bit hold = 1'b0;
    bit prev_done = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit rdy_rand = 1'b0;

    int         pin_idx [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 21, 22, 23, 24, 65, 66, 67, 68, 129};
    logic [7:0] pin_val [18] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h08};
    int         r31_idx [5] = '{125, 126, 127, 128, 129};
    logic [7:0] r31_val [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00};

    reg_dump_sequencer dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .dump_active (dump_active),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Register file read port: data one clock after the address is sampled.
    always @(posedge clock) rd_data <= mem[rd_addr];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: header, every register MSB byte first, XOR of data bytes.
    function automatic void build_exp();
        logic [7:0]  cs = 8'h00;
        logic [31:0] w;
        expb[0] = 8'hA5;
        for (int r = 0; r < 32; r++) begin
            w = mem[r];
            for (int b = 0; b < 4; b++) begin
                expb[1 + 4 * r + b] = w[31 - 8 * b -: 8];
                cs = cs ^ w[31 - 8 * b -: 8];
            end
        end
        expb[FRAME - 1] = cs;
    endfunction

    // Stream monitor: checks every accepted byte, handshake stability and done.
    always @(negedge clock) begin
        if (!reset_n) begin
            pos = 0;
            in_frame = 1'b0;
            hold = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            if (tx_valid) begin
                check("active_with_valid", {31'd0, dump_active}, 32'd1);
                if (!in_frame) begin
                    in_frame = 1'b1;
                    hdr_cyc = cyc;
                    gap = hdr_cyc - done_cyc;
                end
            end
            if (tx_valid && tx_ready) begin
                if (pos < FRAME) begin
                    cap[pos] = tx_data;
                    check($sformatf("byte[%0d]", pos), {24'd0, tx_data}, {24'd0, expb[pos]});
                end else begin
                    check("frame_overrun", pos, FRAME - 1);
                end
                pos++;
            end
            if (done) begin
                check("done_len", pos, FRAME);
                check("done_one_cycle", {31'd0, prev_done}, 32'd0);
                check("done_inactive", {31'd0, dump_active}, 32'd0);
                dones++;
                done_cyc = cyc;
                lat = done_cyc - hdr_cyc + 1;
                pos = 0;
                in_frame = 1'b0;
            end
            prev_done = done;
            hold = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    // UART ready: constant high or random ~30% high.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            tx_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (dones < target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check(name, {31'd0, dones >= target}, 32'd1);
    endtask

    task automatic wait_pos(input int target, input int budget, input string name);
        int n = 0;
        while (pos < target && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check(name, {31'd0, pos >= target}, 32'd1);
    endtask

    task automatic quiet(input int n, input string name);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tx_valid || done) cnt++;
        end
        check(name, cnt, 0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0000;
        mem[1]  = 32'h0000_000A;
        mem[3]  = 32'h0000_0006;
        mem[5]  = 32'hFFFF_FFFB;
        mem[16] = 32'hAAAA_AAAA;
        build_exp();

        // Reset values.
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_dump_active", {31'd0, dump_active}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        reset_n = 1'b1;

        // Full dump with tx_ready high: timing and pinned bytes.
        pulse_start();
        wait_dones(1, 400, "dump1_done");
        check("dump1_latency", lat, 227);
        for (int k = 0; k < 18; k++)
            check($sformatf("pin[%0d]", pin_idx[k]), {24'd0, cap[pin_idx[k]]}, {24'd0, pin_val[k]});

        // Backpressure.
        rdy_rand = 1'b1;
        pulse_start();
        wait_dones(2, 3000, "bp_done");

        // start held high for 500 cycles: frames restart via IDLE.
        rdy_rand = 1'b0;
        d0 = dones;
        @(posedge clock);
        #1 start = 1'b1;
        repeat (500) @(posedge clock);
        #1 start = 1'b0;
        wait_dones(d0 + 3, 400, "held_done");
        quiet(30, "held_quiet");
        check("held_frames", dones - d0, 3);
        check("held_gap", gap, 2);
        check("held_latency", lat, 227);

        // start pulse during SEND of r7 is ignored.
        d0 = dones;
        pulse_start();
        wait_pos(30, 200, "r7_reach");
        pulse_start();
        wait_dones(d0 + 1, 400, "r7_done");
        quiet(40, "r7_quiet");
        check("r7_frames", dones - d0, 1);

        // Reset mid-frame, then a clean frame.
        rdy_rand = 1'b1;
        d0 = dones;
        pulse_start();
        wait_pos(40, 1000, "rst_reach");
        #1 reset_n = 1'b0;
        #1;
        check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_dump_active", {31'd0, dump_active}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        quiet(30, "midrst_quiet");
        check("midrst_no_done", dones - d0, 0);
        pulse_start();
        wait_dones(d0 + 1, 3000, "midrst_frame");
        check("midrst_hdr", {24'd0, cap[0]}, 32'h0000_00A5);

        // r31 = 12345678 zeroes the checksum.
        mem[31] = 32'h1234_5678;
        build_exp();
        d0 = dones;
        pulse_start();
        wait_dones(d0 + 1, 3000, "r31_done");
        for (int k = 0; k < 5; k++)
            check($sformatf("r31_pin[%0d]", r31_idx[k]), {24'd0, cap[r31_idx[k]]}, {24'd0, r31_val[k]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
